// File: rtl/div8x4.sv
// -----------------------------------------------------------------------------
// div8x4 -- sequential restoring divider, one quotient bit per clock.
//
// Divides an unsigned DIVIDEND_W-bit dividend by an unsigned DIVISOR_W-bit
// divisor. Results are registered and only change on the edge that enters
// DONE; they hold until the next accepted start.
//
// Handshake: start is sampled only in IDLE. An accepted start with a nonzero
// divisor moves to RUN (busy=1) for DIVIDEND_W cycles, then DONE (done=1 for
// exactly one cycle), then back to IDLE. A zero divisor goes straight to DONE
// with quotient=all ones, remainder=dividend low bits and div_by_zero=1.
// start is ignored in RUN and DONE; there is no request queuing.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset, highest priority
//   start        in   launch request
//   dividend     in   [DIVIDEND_W-1:0] unsigned dividend
//   divisor      in   [DIVISOR_W-1:0]  unsigned divisor
//   busy         out  high in RUN
//   done         out  one-cycle pulse in DONE
//   quotient     out  [DIVIDEND_W-1:0] result quotient
//   remainder    out  [DIVISOR_W-1:0]  result remainder
//   div_by_zero  out  last operation had divisor == 0
//   state_dbg    out  [1:0] current FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
module div8x4 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Partial remainder is one bit wider than the divisor so the trial
  // subtraction after the left shift can never overflow.
  logic [DIVISOR_W:0]    rem_q, rem_d;
  // Dividend shift register; quotient bits enter at the LSB as dividend
  // bits leave at the MSB, so after DIVIDEND_W steps it holds the quotient.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  // One restoring step, computed combinationally from the working registers.
  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  diff;
  logic                  borrow;
  logic [DIVISOR_W:0]    step_rem;
  logic [DIVIDEND_W-1:0] step_dvd;

  always_comb begin
    shifted  = {rem_q, dvd_q[DIVIDEND_W-1]};
    diff     = shifted - {2'b00, dvs_q};
    // A set MSB means the trial went negative: restore the shifted value.
    borrow   = diff[DIVISOR_W+1];
    step_rem = borrow ? shifted[DIVISOR_W:0] : diff[DIVISOR_W:0];
    step_dvd = {dvd_q[DIVIDEND_W-2:0], ~borrow};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            quo_d   = '1;
            remo_d  = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Final step: the remainder is now below the divisor, so its
          // low DIVISOR_W bits are the whole value.
          quo_d   = step_dvd;
          remo_d  = step_rem[DIVISOR_W-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_div8x4.sv
// -----------------------------------------------------------------------------
// tb_div8x4 -- self-checking bench for div8x4 at default widths (8 / 4).
// Expected results come from plain integer / and % in the bench; latency and
// pulse expectations come from the handshake timing of the block.
// -----------------------------------------------------------------------------
module tb_div8x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [1:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the currently visible result registers.
  logic [7:0] m_q;
  logic [3:0] m_r;

  div8x4 #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + scoreboard for one operation ----------------
  // Launches a/b in cycle 0, then watches cycles 1..12. Inputs are scrambled
  // after acceptance; if inject is nonzero a start of 9/3 is pulsed in that
  // cycle and must be ignored.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int inject);
    logic [7:0] eq;
    logic [3:0] er;
    logic       edz;
    int         elat, ebusy;
    int         done_cnt, done_cyc, busy_cnt, hold_bad;
    logic [7:0] oq;
    logic [3:0] orr;
    logic       odz;
    if (b == 4'd0) begin
      eq = 8'hFF; er = a[3:0]; edz = 1'b1; elat = 1; ebusy = 0;
    end else begin
      eq = 8'(a / b); er = 4'(a % b); edz = 1'b0; elat = 9; ebusy = 8;
    end
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; hold_bad = 0;
    oq = '0; orr = '0; odz = 1'b0;

    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          oq = quotient; orr = remainder; odz = div_by_zero;
        end
      end
      if (done_cnt == 0 && (quotient !== m_q || remainder !== m_r)) hold_bad++;
      start    = (c == inject);
      dividend = (c == inject) ? 8'd9 : 8'($urandom);
      divisor  = (c == inject) ? 4'd3 : 4'($urandom);
      tick();
    end
    start = 1'b0;
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_cyc, elat);
    chk("busy_cycles", busy_cnt, ebusy);
    chk("result_hold_during_run", hold_bad, 0);
    chk("quotient", oq, eq);
    chk("remainder", orr, er);
    chk("div_by_zero", odz, edz);
    chk("quotient_held_after", quotient, eq);
    m_q = eq;
    m_r = er;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int no_done;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    m_q = '0; m_r = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    tick();

    run_op(8'd200, 4'd7, 0);     // 28 r4
    run_op(8'd255, 4'd15, 0);    // 17 r0
    run_op(8'd5,   4'd9, 0);     // 0 r5
    run_op(8'd255, 4'd1, 9);     // start pulse during DONE must be ignored
    run_op(8'h3C,  4'd0, 0);     // divide by zero
    run_op(8'd8,   4'd2, 0);     // clears div_by_zero
    run_op(8'd0,   4'd0, 0);     // zero / zero
    run_op(8'd100, 4'd3, 4);     // start pulse mid-RUN ignored
    run_op(8'd0,   4'd15, 0);

    // Reset mid-RUN: start in cycle 0, rst high in cycle 5.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    no_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) no_done++;
      tick();
    end
    chk("abort_no_done", no_done, 0);
    m_q = '0; m_r = '0;
    run_op(8'd50, 4'd5, 0);

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 4'($urandom_range(1, 15)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div8x4.md
Name: div8x4

Overview:
- Sequential restoring divider; the inverse operation of the combinational 4x4 multiplier.
- Divides an unsigned DIVIDEND_W-bit dividend by an unsigned DIVISOR_W-bit divisor, one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag through a start/busy/done handshake.
- Sits beside the multiplier in the ALU datapath. The ALU control FSM launches it and waits for done.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; must be >= DIVISOR_W.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  launch request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  unsigned dividend; captured on accepted start.
- divisor  input  DIVISOR_W  unsigned divisor; captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DIVIDEND_W  result quotient.
- remainder  output  DIVISOR_W  result remainder.
- div_by_zero  output  1  set when the last operation had divisor == 0.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal counter and registers cleared.
- Reset has priority over all other inputs. Asserting rst mid-RUN aborts the operation, and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1, divisor!=0:
  - Capture dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (DIVISOR_W+1 bits).
  - Load the counter with DIVIDEND_W and go to RUN.
- IDLE, start=1, divisor==0:
  - Go directly to DONE.
  - quotient={DIVIDEND_W{1'b1}}, remainder=dividend[DIVISOR_W-1:0], div_by_zero=1.
- IDLE, start=0: stay in IDLE. Outputs hold the previous result.
- RUN, each cycle (one restoring step):
  - Shift {partial remainder, dividend register} left by 1.
  - Trial = shifted remainder - divisor.
  - If the trial is non-negative (no borrow): keep the trial and shift 1 into the quotient LSB.
  - Otherwise: keep the shifted remainder and shift in 0.
  - Decrement the counter. After the DIVIDEND_W-th step go to DONE.
- DONE: done=1 for exactly one cycle.
  - quotient, remainder and div_by_zero update on the edge entering DONE and hold until the next accepted start.
  - div_by_zero is cleared on the next accepted start with a nonzero divisor.
  - Returns to IDLE on the next edge.
- Latency:
  - start high in cycle 0 (accepted) -> busy high cycles 1..DIVIDEND_W -> done high in cycle DIVIDEND_W+1 (cycle 9 at defaults).
  - Divide-by-zero: done high in cycle 1 and busy never asserts.
- Back-to-back: start is ignored in RUN and DONE (no queuing). The earliest re-launch is the cycle after DONE.
- Dividend and divisor inputs may change freely after the accepting edge.
- Arithmetic:
  - The partial remainder is DIVISOR_W+1 bits wide so the trial subtraction never overflows.
  - The final remainder is always < divisor, so it fits DIVISOR_W bits.
  - Invariant: quotient*divisor + remainder == dividend.
- Unchanged outputs: quotient and remainder are not modified during RUN. Internal working registers are separate, and the outputs update only on entering DONE.

Test Plan:
- Reset then start with dividend=200, divisor=7 -> busy cycles 1-8, done in cycle 9, quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=15 -> quotient=17, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5. Then dividend=255, divisor=1 -> quotient=255, remainder=0.
- dividend=0x3C, divisor=0 -> done in cycle 1, busy never high, quotient=0xFF, remainder=0xC, div_by_zero=1. A following 8/2 run -> quotient=4, remainder=0, div_by_zero=0.
- Start 100/3, pulse start with 9/3 during cycle 4 of RUN, and change the inputs mid-RUN -> single done, quotient=33, remainder=1.
- Start 200/7, assert rst in cycle 5 -> busy=0 and all outputs 0 next cycle, no done pulse. A new start of 50/5 afterwards -> quotient=10, remainder=0.
- Randomised: 1000 random dividend/divisor pairs, divisor != 0 -> quotient == dividend/divisor, remainder == dividend%divisor, done exactly 9 cycles after start.
